// File: rtl/booth_multiplier_iter_pkg.sv
// booth_multiplier_iter_pkg
//   Shared definitions for the iterative radix-2 Booth multiplier:
//   FSM state encoding, carry-lookahead slice width, Booth operation
//   codes and the helper that decodes a Booth bit pair into an operation.
package booth_multiplier_iter_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of the current multiplier bit and the bit
    // shifted out on the previous step: 01 adds M, 10 subtracts M.
    function automatic booth_op_e booth_decode(input logic l0, input logic q1);
        booth_op_e op;
        case ({l0, q1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_multiplier_iter_if.sv
// booth_multiplier_iter_if
//   Execute-stage handshake bundle for the multiplier.
//   master (pipeline side): drives ctrl_mult and the two operands,
//                           observes result, exception, resultRDY and busy.
//   slave  (multiplier)   : the reverse.
interface booth_multiplier_iter_if
    import booth_multiplier_iter_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic             ctrl_mult;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_mult, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_mult, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/booth_multiplier_iter_cla_carry_unit.sv
// cla_carry_unit
//   Purely combinational lookahead carry generator across NSLICE adder slices.
//   Ports: grp_g / grp_p (per-slice group generate / propagate), cin,
//          carry[NSLICE:0] (carry[0] = cin, carry[i] feeds slice i,
//          carry[NSLICE] is the carry out of the top slice).
module cla_carry_unit #(
    parameter int NSLICE = 4
) (
    input  logic [NSLICE-1:0] grp_g,
    input  logic [NSLICE-1:0] grp_p,
    input  logic              cin,
    output logic [NSLICE:0]   carry
);

    // Each carry is formed as a flat sum of products of the group terms and
    // cin, so no slice carry waits on the carry of the slice below it:
    //   c[i+1] = G[i] | P[i]G[i-1] | ... | P[i]..P[0]cin
    always_comb begin
        logic acc;
        logic run_p;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < NSLICE; i++) begin
            acc   = grp_g[i];
            run_p = grp_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc   = acc | (run_p & grp_g[j]);
                run_p = run_p & grp_p[j];
            end
            carry[i+1] = acc | (run_p & cin);
        end
    end

endmodule

// File: rtl/booth_multiplier_iter_cla_slice8.sv
// cla_slice8
//   The 8-bit carry-lookahead adder slice shared with the ALU datapath.
//   Ports: a, b (8-bit addends), cin (slice carry-in),
//          sum (8-bit sum), grp_g / grp_p (group generate / propagate).
module cla_slice8
    import booth_multiplier_iter_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               grp_g,
    output logic               grp_p
);

    logic [SLICE_W-1:0] bit_g;
    logic [SLICE_W-1:0] bit_p;

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    // Bit-level sum plus the group generate/propagate terms that let the
    // carry unit skip over this slice without waiting on its internal carries.
    always_comb begin
        logic carry;
        logic gen;
        sum   = '0;
        carry = cin;
        gen   = 1'b0;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i] = bit_p[i] ^ carry;
            carry  = bit_g[i] | (bit_p[i] & carry);
            gen    = bit_g[i] | (bit_p[i] & gen);
        end
        grp_g = gen;
        grp_p = &bit_p;
    end

endmodule

// File: rtl/booth_multiplier_iter.sv
// booth_multiplier_iter
//   Multi-cycle signed WIDTH x WIDTH radix-2 Booth multiplier.
//   Ports: clock, reset_n (async active-low),
//          bus.ctrl_mult / data_operandA / data_operandB (start + operands),
//          bus.data_result (low WIDTH product bits), bus.data_exception
//          (product overflows signed WIDTH), bus.data_resultRDY (1-cycle
//          result strobe), bus.busy (operation in flight).
module booth_multiplier_iter
    import booth_multiplier_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                          clock,
    input  logic                          reset_n,
    booth_multiplier_iter_if.slave        bus
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e            state;
    state_e            state_next;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH:0]    m_reg;
    logic [WIDTH:0]    h_reg;
    logic [WIDTH-1:0]  l_reg;
    logic              q_1;
    logic [CNT_W-1:0]  counter;
    logic [WIDTH-1:0]  result_reg;
    logic              exception_reg;
    logic              rdy_reg;
    logic              busy_reg;

    booth_op_e         op;
    logic [WIDTH:0]    addend;
    logic              add_cin;
    logic [WIDTH:0]    adder_sum;
    logic [NSLICE-1:0] slice_g;
    logic [NSLICE-1:0] slice_p;
    logic [NSLICE:0]   carry;
    logic [WIDTH:0]    upper_bits;
    logic              overflow;

    // Booth step operand selection; subtraction is H + ~M with carry-in 1.
    always_comb begin
        op      = booth_decode(l_reg[0], q_1);
        addend  = '0;
        add_cin = 1'b0;
        case (op)
            BOOTH_ADD: addend = m_reg;
            BOOTH_SUB: begin
                addend  = ~m_reg;
                add_cin = 1'b1;
            end
            default: begin
                addend  = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    for (genvar s = 0; s < NSLICE; s++) begin : g_slice
        cla_slice8 u_slice (
            .a     (h_reg[s*SLICE_W +: SLICE_W]),
            .b     (addend[s*SLICE_W +: SLICE_W]),
            .cin   (carry[s]),
            .sum   (adder_sum[s*SLICE_W +: SLICE_W]),
            .grp_g (slice_g[s]),
            .grp_p (slice_p[s])
        );
    end

    cla_carry_unit #(
        .NSLICE (NSLICE)
    ) u_carry (
        .grp_g (slice_g),
        .grp_p (slice_p),
        .cin   (add_cin),
        .carry (carry)
    );

    // The extra sign bit above the slices keeps H one bit wider than the
    // operands so that subtracting the most negative M cannot wrap.
    assign adder_sum[WIDTH] = h_reg[WIDTH] ^ addend[WIDTH] ^ carry[NSLICE];

    // The product fits in signed WIDTH bits only when bit WIDTH-1 and every
    // bit above it in the 2*WIDTH-bit product agree.
    assign upper_bits = {h_reg[WIDTH-1:0], l_reg[WIDTH-1]};
    assign overflow   = !((&upper_bits) || (~|upper_bits));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a start pulse always wins and (re)enters LOAD,
    // which also covers restart during LOAD/RUN and back-to-back from DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.ctrl_mult) state_next = LOAD;
            LOAD: state_next = bus.ctrl_mult ? LOAD : RUN;
            RUN: begin
                if (bus.ctrl_mult) begin
                    state_next = LOAD;
                end else if (counter == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = bus.ctrl_mult ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operands are captured on the start edge, loaded into the
    // Booth registers in LOAD, shifted once per RUN cycle, and the result
    // registers are only touched in DONE so they hold between operations.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_a          <= '0;
            op_b          <= '0;
            m_reg         <= '0;
            h_reg         <= '0;
            l_reg         <= '0;
            q_1           <= 1'b0;
            counter       <= '0;
            result_reg    <= '0;
            exception_reg <= 1'b0;
            rdy_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            rdy_reg <= 1'b0;
            if (bus.ctrl_mult) begin
                op_a <= bus.data_operandA;
                op_b <= bus.data_operandB;
            end
            case (state)
                LOAD: begin
                    m_reg    <= {op_a[WIDTH-1], op_a};
                    h_reg    <= '0;
                    l_reg    <= op_b;
                    q_1      <= 1'b0;
                    counter  <= '0;
                    busy_reg <= 1'b1;
                end
                RUN: begin
                    h_reg   <= {adder_sum[WIDTH], adder_sum[WIDTH:1]};
                    l_reg   <= {adder_sum[0], l_reg[WIDTH-1:1]};
                    q_1     <= l_reg[0];
                    counter <= counter + CNT_W'(1);
                end
                DONE: begin
                    result_reg    <= l_reg;
                    exception_reg <= overflow;
                    rdy_reg       <= 1'b1;
                    busy_reg      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.data_result    = result_reg;
    assign bus.data_exception = exception_reg;
    assign bus.data_resultRDY = rdy_reg;
    assign bus.busy           = busy_reg;

endmodule
